// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: conditions the raw lines, deserialises 11-bit frames,
// and turns make codes into ASCII with shift/break/extended prefix tracking.
module ps2_keyboard_rx #(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 25000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] ascii_code,
  output logic       new_key,
  output logic [7:0] scan_code,
  output logic       scan_valid,
  output logic       frame_error
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [1:0]    clk_sync, data_sync;
  logic          clk_s, data_s;
  logic          filt_clk, filt_prev, strobe;
  logic [FW-1:0] filt_cnt;
  state_t        state_q, state_d;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_q;
  logic          parity_q;
  logic [TW-1:0] tmo_cnt;
  logic          frame_done, frame_good, timeout, bad_frame;
  logic          brk, ext, lshift, rshift;
  logic [8:0]    lookup;

  assign clk_s  = clk_sync[1];
  assign data_s = data_sync[1];
  assign strobe = filt_prev & ~filt_clk;

  // NOTE: every clocked block uses non-blocking assignments so all flops update
  // from the same pre-edge values, independent of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      filt_clk  <= 1'b1;
      filt_prev <= 1'b1;
      filt_cnt  <= '0;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
      filt_prev <= filt_clk;
      if (clk_s == filt_clk) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        filt_clk <= clk_s;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  // NOTE: all always_comb outputs get a default first so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    frame_done = 1'b0;
    frame_good = 1'b0;
    timeout    = 1'b0;
    if (state_q != IDLE && !strobe && tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
      timeout = 1'b1;
      state_d = IDLE;
    end else if (strobe) begin
      unique case (state_q)
        IDLE:   if (!data_s) state_d = DATA;
        DATA:   if (bit_cnt == 3'd7) state_d = PARITY;
        PARITY: state_d = STOP;
        STOP: begin
          frame_done = 1'b1;
          frame_good = data_s & (^{shift_q, parity_q});
          state_d    = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bad_frame = timeout | (frame_done & ~frame_good);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      bit_cnt  <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      tmo_cnt  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE || strobe) tmo_cnt <= '0;
      else                          tmo_cnt <= tmo_cnt + 1'b1;
      if (strobe) begin
        unique case (state_q)
          IDLE: bit_cnt <= '0;
          DATA: begin
            shift_q <= {data_s, shift_q[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
          end
          PARITY:  parity_q <= data_s;
          default: ;
        endcase
      end
    end
  end

  // Returns {mapped, ascii} for a make code; letters follow the shift state.
  function automatic logic [8:0] decode_key(input logic [7:0] b, input logic shifted);
    logic [7:0] base;
    logic [8:0] r;
    base = shifted ? 8'h41 : 8'h61;
    r    = '0;
    case (b)
      8'h1C: r = {1'b1, base};
      8'h32: r = {1'b1, base + 8'd1};
      8'h21: r = {1'b1, base + 8'd2};
      8'h23: r = {1'b1, base + 8'd3};
      8'h24: r = {1'b1, base + 8'd4};
      8'h2B: r = {1'b1, base + 8'd5};
      8'h34: r = {1'b1, base + 8'd6};
      8'h33: r = {1'b1, base + 8'd7};
      8'h43: r = {1'b1, base + 8'd8};
      8'h3B: r = {1'b1, base + 8'd9};
      8'h42: r = {1'b1, base + 8'd10};
      8'h4B: r = {1'b1, base + 8'd11};
      8'h3A: r = {1'b1, base + 8'd12};
      8'h31: r = {1'b1, base + 8'd13};
      8'h44: r = {1'b1, base + 8'd14};
      8'h4D: r = {1'b1, base + 8'd15};
      8'h15: r = {1'b1, base + 8'd16};
      8'h2D: r = {1'b1, base + 8'd17};
      8'h1B: r = {1'b1, base + 8'd18};
      8'h2C: r = {1'b1, base + 8'd19};
      8'h3C: r = {1'b1, base + 8'd20};
      8'h2A: r = {1'b1, base + 8'd21};
      8'h1D: r = {1'b1, base + 8'd22};
      8'h22: r = {1'b1, base + 8'd23};
      8'h35: r = {1'b1, base + 8'd24};
      8'h1A: r = {1'b1, base + 8'd25};
      8'h45: r = {1'b1, 8'h30};
      8'h16: r = {1'b1, 8'h31};
      8'h1E: r = {1'b1, 8'h32};
      8'h26: r = {1'b1, 8'h33};
      8'h25: r = {1'b1, 8'h34};
      8'h2E: r = {1'b1, 8'h35};
      8'h36: r = {1'b1, 8'h36};
      8'h3D: r = {1'b1, 8'h37};
      8'h3E: r = {1'b1, 8'h38};
      8'h46: r = {1'b1, 8'h39};
      8'h29: r = {1'b1, 8'h20};
      8'h5A: r = {1'b1, 8'h0D};
      8'h66: r = {1'b1, 8'h08};
      default: r = '0;
    endcase
    return r;
  endfunction

  assign lookup = decode_key(shift_q, lshift | rshift);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ascii_code  <= '0;
      scan_code   <= '0;
      new_key     <= 1'b0;
      scan_valid  <= 1'b0;
      frame_error <= 1'b0;
      brk         <= 1'b0;
      ext         <= 1'b0;
      lshift      <= 1'b0;
      rshift      <= 1'b0;
    end else begin
      new_key     <= 1'b0;
      scan_valid  <= frame_good;
      frame_error <= bad_frame;
      if (bad_frame) begin
        brk <= 1'b0;
        ext <= 1'b0;
      end else if (frame_good) begin
        scan_code <= shift_q;
        if (shift_q == 8'hE0) begin
          ext <= 1'b1;
        end else if (shift_q == 8'hF0) begin
          brk <= 1'b1;
        end else begin
          if (shift_q == 8'h12) begin
            lshift <= ~brk;
          end else if (shift_q == 8'h59) begin
            rshift <= ~brk;
          end else if (!brk && !ext && lookup[8]) begin
            new_key    <= 1'b1;
            ascii_code <= lookup[7:0];
          end
          brk <= 1'b0;
          ext <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Self-checking bench for ps2_keyboard_rx: a table of frames drives a scoreboard
// queue, a monitor pops one expectation per output pulse.
module tb_ps2_keyboard_rx;

  localparam int TMO  = 200;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       reset, ps2_clk, ps2_data;
  logic [7:0] ascii_code, scan_code;
  logic       new_key, scan_valid, frame_error;

  always #5 clk = ~clk;

  ps2_keyboard_rx #(.FILTER_LEN(4), .TIMEOUT_CYCLES(TMO)) dut (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .ascii_code (ascii_code),
    .new_key    (new_key),
    .scan_code  (scan_code),
    .scan_valid (scan_valid),
    .frame_error(frame_error)
  );

  typedef struct {
    logic       sv, nk, fe;
    logic [7:0] scan, ascii;
  } exp_t;

  typedef struct {
    logic [7:0] b;
    logic       bad_par, bad_stop, nk;
    logic [7:0] ascii;
  } vec_t;

  exp_t       exp_q[$];
  vec_t       vecs[$];
  exp_t       mon_e;
  int         checks   = 0;
  int         failures = 0;
  logic [7:0] model_scan = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ps2_bit(input logic v);
    ps2_data = v;
    wait_clks(HALF);
    ps2_clk = 1'b0;
    wait_clks(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0) break;
      wait_clks(1);
    end
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    wait_clks(2 * HALF);
  endtask

  task automatic push_exp(input logic sv, input logic nk, input logic fe, input logic [7:0] ascii);
    exp_t e;
    e.sv = sv; e.nk = nk; e.fe = fe; e.scan = model_scan; e.ascii = ascii;
    exp_q.push_back(e);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop,
                            input logic nk, input logic [7:0] ascii);
    logic good;
    good = !bad_par && !bad_stop;
    if (good) model_scan = b;
    push_exp(good, nk, !good, ascii);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit((~^b) ^ bad_par);
    ps2_bit(!bad_stop);
    ps2_data = 1'b1;
    wait_drain(100);
  endtask

  task automatic add(input logic [7:0] b, input logic bp, input logic bs,
                     input logic nk, input logic [7:0] a);
    vec_t v;
    v.b = b; v.bad_par = bp; v.bad_stop = bs; v.nk = nk; v.ascii = a;
    vecs.push_back(v);
  endtask

  task automatic check_reset_state();
    check("rst_ascii_code", 32'(ascii_code), 32'h00);
    check("rst_scan_code", 32'(scan_code), 32'h00);
    check("rst_pulses", 32'({scan_valid, new_key, frame_error}), 32'd0);
  endtask

  // Every pulse must match the oldest outstanding expectation; extras are errors.
  always @(negedge clk) begin
    if (!reset && (scan_valid || new_key || frame_error)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", 32'({scan_valid, new_key, frame_error}), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("scan_valid", 32'(scan_valid), 32'(mon_e.sv));
        check("new_key", 32'(new_key), 32'(mon_e.nk));
        check("frame_error", 32'(frame_error), 32'(mon_e.fe));
        check("scan_code", 32'(scan_code), 32'(mon_e.scan));
        check("ascii_code", 32'(ascii_code), 32'(mon_e.ascii));
      end
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // {byte, bad parity, bad stop, expect new_key, expected ascii_code afterwards}
    add(8'h1C, 0, 0, 1, 8'h61);
    add(8'h12, 0, 0, 0, 8'h61);
    add(8'h1C, 0, 0, 1, 8'h41);
    add(8'hF0, 0, 0, 0, 8'h41);
    add(8'h1C, 0, 0, 0, 8'h41);
    add(8'hF0, 0, 0, 0, 8'h41);
    add(8'h12, 0, 0, 0, 8'h41);
    add(8'h1C, 0, 0, 1, 8'h61);
    add(8'h1C, 1, 0, 0, 8'h61);
    add(8'h16, 0, 0, 1, 8'h31);
    add(8'hE0, 0, 0, 0, 8'h31);
    add(8'h75, 0, 0, 0, 8'h31);
    add(8'hE0, 0, 0, 0, 8'h31);
    add(8'hF0, 0, 0, 0, 8'h31);
    add(8'h75, 0, 0, 0, 8'h31);
    add(8'h5A, 0, 0, 1, 8'h0D);
    add(8'hF0, 0, 0, 0, 8'h0D);
    add(8'h1C, 1, 0, 0, 8'h0D);
    add(8'h1C, 0, 0, 1, 8'h61);
    add(8'hE0, 0, 0, 0, 8'h61);
    add(8'h45, 0, 1, 0, 8'h61);
    add(8'h45, 0, 0, 1, 8'h30);
    add(8'h59, 0, 0, 0, 8'h30);
    add(8'h4D, 0, 0, 1, 8'h50);
    add(8'h3E, 0, 0, 1, 8'h38);
    add(8'hF0, 0, 0, 0, 8'h38);
    add(8'h59, 0, 0, 0, 8'h38);
    add(8'h1A, 0, 0, 1, 8'h7A);
    add(8'h66, 0, 0, 1, 8'h08);
    add(8'h05, 0, 0, 0, 8'h08);
    add(8'h2C, 0, 0, 1, 8'h74);
    add(8'hE0, 0, 0, 0, 8'h74);
    add(8'h1C, 0, 0, 0, 8'h74);

    reset    = 1'b1;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    wait_clks(4);
    check_reset_state();
    reset = 1'b0;
    wait_clks(10);

    foreach (vecs[i]) send_frame(vecs[i].b, vecs[i].bad_par, vecs[i].bad_stop,
                                 vecs[i].nk, vecs[i].ascii);

    // Frame abandoned after five data bits: only the timeout may end it.
    push_exp(1'b0, 1'b0, 1'b1, 8'h74);
    ps2_bit(1'b0);
    for (int i = 0; i < 5; i++) ps2_bit(i[0] ? 1'b0 : 1'b1);
    ps2_data = 1'b1;
    wait_drain(TMO + 100);
    send_frame(8'h29, 0, 0, 1, 8'h20);

    // Two-cycle clock glitch with data low would start a frame if it got through.
    ps2_data = 1'b0;
    ps2_clk  = 1'b0;
    wait_clks(2);
    ps2_clk = 1'b1;
    wait_clks(10);
    ps2_data = 1'b1;
    wait_clks(TMO + 50);
    send_frame(8'h5A, 0, 0, 1, 8'h0D);

    // Shift held, then reset lands in the middle of a frame.
    send_frame(8'h12, 0, 0, 0, 8'h0D);
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(i < 2 ? 1'b0 : 1'b1);
    wait_clks(5);
    reset = 1'b1;
    wait_clks(3);
    check_reset_state();
    model_scan = 8'h00;
    reset      = 1'b0;
    ps2_data   = 1'b1;
    wait_clks(TMO + 50);
    send_frame(8'h24, 0, 0, 1, 8'h65);

    wait_clks(50);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_keyboard_rx.md
Name: ps2_keyboard_rx

Overview:
- PS/2 keyboard receiver and scan-code decoder.
- Sits directly upstream of the character display path: it drives the ascii_code / new_key pair that latches the displayed character.
- Synchronises and de-glitches the PS/2 lines, deserialises 11-bit frames, checks parity, and tracks make/break/extended/shift prefixes.
- Emits a one-cycle new_key pulse with the ASCII code for printable make codes.

Parameters:
- FILTER_LEN, 4: consecutive identical synchronised ps2_clk samples required before the filtered clock changes level.
- TIMEOUT_CYCLES, 25000: clk cycles without a falling edge, while mid-frame, before the frame is aborted (1 ms at 25 MHz).

Ports:
- clk  in  1  system/pixel clock.
- reset  in  1  asynchronous, active-high.
- ps2_clk  in  1  raw PS/2 clock from the keyboard, asynchronous.
- ps2_data  in  1  raw PS/2 data from the keyboard, asynchronous.
- ascii_code  out  8  last decoded ASCII character; held between keys.
- new_key  out  1  one-cycle pulse; ascii_code is valid and updated in this cycle.
- scan_code  out  8  last correctly received raw byte; held.
- scan_valid  out  1  one-cycle pulse per good frame, including prefix bytes.
- frame_error  out  1  one-cycle pulse on a parity error, stop-bit error or timeout.

Behaviour:
- Clock and reset: reset is asynchronous, active-high; clock is clk.
- Reset values:
  - ascii_code = 0x00, scan_code = 0x00; all pulse outputs = 0.
  - FSM = IDLE; all prefix and shift flags cleared.
  - Sync flops and filtered clock reset to 1 (line idle level).
- Input conditioning:
  - Two-flop synchroniser on each PS/2 line.
  - filt_clk takes the synced ps2_clk value only after FILTER_LEN consecutive equal samples.
  - strobe = filt_clk 1->0 transition (one clk wide). The synced ps2_data is sampled in the strobe cycle.
- Frame FSM (advances on strobe only):
  - IDLE: data=0 -> DATA with bit_cnt=0; data=1 -> stay in IDLE (spurious edge ignored, no error).
  - DATA: shift in LSB first; after the 8th bit -> PARITY.
  - PARITY: store the parity bit; -> STOP.
  - STOP: good frame when stop=1 AND the XOR of the 8 data bits and the parity bit = 1 (odd parity). Otherwise frame_error. Always -> IDLE.
- Timeout:
  - Counter clears on every strobe and is held at 0 in IDLE.
  - In DATA/PARITY/STOP, reaching TIMEOUT_CYCLES-1 -> IDLE and a frame_error pulse.
- Error side effects: a frame_error also clears the break and extended flags. scan_code and ascii_code are unchanged.
- Output latency: scan_valid, new_key and frame_error are registered and assert in the clk cycle after the stop-bit strobe. scan_valid and new_key are coincident.
- Decoder, applied to each good byte b:
  - b=0xE0: set ext. b=0xF0: set brk. No new_key for either.
  - b=0x12 or 0x59 (left/right shift): that shift flag <= !brk.
  - Any other b: new_key only if !brk, !ext and b is in the map.
  - After every non-prefix byte, clear brk and ext.
- Map, letters: 1C A, 32 B, 21 C, 23 D, 24 E, 2B F, 34 G, 33 H, 43 I, 3B J, 42 K, 4B L, 3A M, 31 N, 44 O, 4D P, 15 Q, 2D R, 1B S, 2C T, 3C U, 2A V, 1D W, 22 X, 35 Y, 1A Z.
  - Output is uppercase (0x41..) when either shift flag is set, lowercase (0x61..) otherwise.
- Map, digits (shift ignored): 45 0, 16 1, 1E 2, 26 3, 25 4, 2E 5, 36 6, 3D 7, 3E 8, 46 9.
- Map, other keys: 29 -> 0x20 (space), 5A -> 0x0D (enter), 66 -> 0x08 (backspace).
- Unmapped make codes: scan_valid only.
- Reset mid-frame: the partial frame is discarded with no pulses of any kind.
- Reset during a held shift key clears the shift flag.

Test Plan:
- Good frame 0x1C (parity 0, stop 1) at 12.5 kHz, clk 25 MHz -> scan_valid and new_key for exactly one cycle, scan_code=0x1C, ascii_code=0x61.
- Sequence 12, 1C, F0 1C, F0 12, 1C -> new_key with 0x41, then new_key with 0x61. No new_key on the break or shift bytes.
- Frame 0x1C with the parity bit flipped -> frame_error pulse, no scan_valid, ascii_code unchanged. A following 0x16 -> ascii_code 0x31.
- Frame stops after 5 data bits, then idle for TIMEOUT_CYCLES -> one frame_error pulse, FSM back in IDLE. A following good 0x29 -> ascii_code 0x20.
- E0 75, then E0 F0 75 -> scan_valid 5 times, no new_key. A following 0x5A -> 0x0D. A 2-cycle low glitch on ps2_clk -> ignored.
- reset asserted after the 4th data bit of 0x1C, released, then a full 0x24 frame sent -> no pulses for the aborted frame, ascii_code=0x65.
